bitstream_prefetch: RTL and testbench

- Sits between the behavioural/external bitstream RAM and the nova BitStream_buffer_input port.
- Fetches 16-bit bitstream words from a base address for a programmed word count.
- Buffers the words in a small FIFO and hands them to the decoder over a valid/ready handshake, hiding RAM read latency and decoder stalls.

---
 rtl/bitstream_prefetch_pkg.sv | 17 +
 rtl/bitstream_prefetch_fifo.sv | 64 ++++++
 rtl/bitstream_prefetch.sv | 139 +++++++++++++
 tb/tb_bitstream_prefetch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bitstream_prefetch_pkg.sv
// Shared types and constants for the bitstream prefetcher and its FIFO.
package bitstream_prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  localparam logic [15:0] START_CODE_HI = 16'h0000;
  localparam logic [15:0] START_CODE_LO = 16'h0001;

  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_ADDR_W = 17;
  localparam int unsigned DEF_DATA_W = 16;

endpackage

// File: rtl/bitstream_prefetch_fifo.sv
// Synchronous FIFO with occupancy count; when empty, rd_data keeps the last word popped.
module sync_fifo
  import bitstream_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     count_q;
  logic [DATA_W-1:0] last_q;
  logic              do_wr, do_rd;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign do_wr   = wr_en && !full && !flush;
  assign do_rd   = rd_en && !empty && !flush;
  assign rd_data = empty ? last_q : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bitstream_prefetch.sv
// Bitstream RAM prefetcher: credit-limited reads into a FIFO feeding a valid/ready consumer.
// Optional START_CODE_DETECT_EN adds a start_code flag on 00 00 00 01 word pairs.
module bitstream_prefetch
  import bitstream_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W:0]        word_count,
  input  logic                   flush,
  output logic                   ram_ren,
  output logic [ADDR_W-1:0]      ram_addr,
  input  logic [DATA_W-1:0]      ram_data,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level
`ifdef START_CODE_DETECT_EN
  ,
  output logic                   start_code
`endif
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              inflight_q;
  logic              done_q, done_d;
  logic              ren, pop, credit;
  logic              fifo_full, fifo_empty;
  logic [LW:0]       occ;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (inflight_q),
    .wr_data (ram_data),
    .rd_en   (pop),
    .rd_data (out_data),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // A read in flight already owns a FIFO slot, so it counts against the credit.
  assign occ       = {1'b0, level} + {{LW{1'b0}}, inflight_q};
  assign credit    = (occ < (LW+1)'(DEPTH)) && !fifo_full;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    ren         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = word_count;
          if (word_count == '0) done_d  = 1'b1;
          else                  state_d = FETCH;
        end
      end
      FETCH: begin
        if (remaining_q != '0 && credit) begin
          ren         = 1'b1;
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W+1)'(1);
        end
        if (remaining_d == '0) state_d = DRAIN;
      end
      DRAIN: begin
        // Finish on the edge that pops the final word so done aligns with busy falling.
        if (!inflight_q && (level == '0 || (level == LW'(1) && pop))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      addr_d      = addr_q;
      remaining_d = '0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= ren && !flush;
      done_q      <= done_d;
    end
  end

  assign ram_ren  = ren;
  assign ram_addr = addr_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

`ifdef START_CODE_DETECT_EN
  logic prev_zero_q;
  logic start_acc;

  assign start_acc  = start && (state_q == IDLE) && !flush;
  assign start_code = pop && prev_zero_q && (out_data == DATA_W'(START_CODE_LO));

  always_ff @(posedge clk) begin
    if (reset)                  prev_zero_q <= 1'b0;
    else if (flush || start_acc) prev_zero_q <= 1'b0;
    else if (pop)               prev_zero_q <= (out_data == DATA_W'(START_CODE_HI));
  end
`endif

endmodule

// File: tb/tb_bitstream_prefetch.sv
// Directed, table-driven bench for bitstream_prefetch with a behavioural 1-cycle-latency RAM.
module tb_bitstream_prefetch;

  logic        clk;
  logic        reset;
  logic        start;
  logic [16:0] base_addr;
  logic [17:0] word_count;
  logic        flush;
  logic        ram_ren;
  logic [16:0] ram_addr;
  logic [15:0] ram_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [3:0]  level;
`ifdef START_CODE_DETECT_EN
  logic        start_code;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  bitstream_prefetch #(
    .DEPTH  (8),
    .ADDR_W (17),
    .DATA_W (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .flush      (flush),
    .ram_ren    (ram_ren),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .level      (level)
`ifdef START_CODE_DETECT_EN
    ,
    .start_code (start_code)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ram_word(input logic [16:0] a);
    if (a == 17'h00200) return 16'h0000;
    if (a == 17'h00201) return 16'h0001;
    if (a == 17'h00202) return 16'h0067;
    return a[15:0] ^ {a[16], 15'h2A5A};
  endfunction

  always @(posedge clk) begin
    if (ram_ren) ram_data <= ram_word(ram_addr);
  end

  typedef struct {
    logic [16:0] base;
    logic [17:0] count;
    int          stall;
    logic [7:0]  rmask;
    int          exp_rens;
    logic [3:0]  exp_level;
    logic [16:0] exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(input vec_t v);
    int unsigned nren, nword;
    bit          exp_done, held, finished;
    logic [15:0] held_d;
    logic [16:0] exp_addr, last_addr;
`ifdef START_CODE_DETECT_EN
    bit          prev_zero;
    prev_zero = 1'b0;
`endif
    nren = 0; nword = 0; held = 1'b0; finished = 1'b0;
    held_d = '0; last_addr = '0;
    exp_done = (v.count == '0);
    base_addr = v.base; word_count = v.count; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400 && !finished; i++) begin
      out_ready = (i < v.stall) ? 1'b0 : v.rmask[i % 8];
      #1;
      if (v.stall != 0 && i == v.stall) begin
        chk("rens_at_release", nren, 32'(v.exp_rens));
        chk("level_at_release", 32'(level), 32'(v.exp_level));
      end
      if (i < 8 && 32'(i) < 32'(v.count)) chk("ren_burst", 32'(ram_ren), 32'd1);
      if (v.count != '0 && i < 2)  chk("first_valid_lat", 32'(out_valid), 32'd0);
      if (v.count != '0 && i == 2) chk("first_valid", 32'(out_valid), 32'd1);
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("no_ren_at_done", 32'(ram_ren), 32'd0);
        finished = 1'b1;
      end else begin
        chk("busy", 32'(busy), 32'd1);
        if (held) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'(out_data), 32'(held_d));
        end
        if (ram_ren) begin
          chk("ren_count_bound", 32'(nren < 32'(v.count)), 32'd1);
          exp_addr = v.base + 17'(nren);
          chk("ren_addr", 32'(ram_addr), 32'(exp_addr));
          last_addr = ram_addr;
          nren++;
        end
        if (out_valid && out_ready) begin
          chk("word", 32'(out_data), 32'(ram_word(v.base + 17'(nword))));
`ifdef START_CODE_DETECT_EN
          chk("start_code", 32'(start_code), 32'(prev_zero && out_data == 16'h0001));
          prev_zero = (out_data == 16'h0000);
`endif
          nword++;
          if (nword == 32'(v.count)) exp_done = 1'b1;
          held = 1'b0;
        end else begin
`ifdef START_CODE_DETECT_EN
          chk("start_code_idle", 32'(start_code), 32'd0);
`endif
          held   = out_valid;
          held_d = out_data;
        end
        chk("level_bound", 32'(level <= 4'd8), 32'd1);
      end
      if (!finished) tick();
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL timeout: base=0x%0h words=%0d of %0d", v.base, nword, v.count);
    end
    chk("rens_total", nren, 32'(v.count));
    chk("words_total", nword, 32'(v.count));
    if (v.count != '0) chk("last_addr", 32'(last_addr), 32'(v.exp_last));
  endtask

  task automatic start_and_run(input logic [16:0] b, input logic [17:0] c, input int n);
    base_addr = b; word_count = c; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (n - 1) tick();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ren"},   32'(ram_ren),   32'd0);
    chk({tag, "_addr"},  32'(ram_addr),  32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"},  32'(out_data),  32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
    chk({tag, "_level"}, 32'(level),     32'd0);
  endtask

  vec_t vecs[8];
  vec_t vf;

  initial begin
    vecs[0] = '{17'h00010, 18'd5,  0,  8'hFF,       0, 4'd0, 17'h00014};
    vecs[1] = '{17'h00040, 18'd20, 30, 8'hFF,       8, 4'd8, 17'h00053};
    vecs[2] = '{17'h1FFFE, 18'd4,  0,  8'hFF,       0, 4'd0, 17'h00001};
    vecs[3] = '{17'h00000, 18'd0,  0,  8'hFF,       0, 4'd0, 17'h00000};
    vecs[4] = '{17'h00300, 18'd12, 0,  8'b10110110, 0, 4'd0, 17'h0030B};
    vecs[5] = '{17'h1FFF0, 18'd9,  3,  8'h55,       3, 4'd2, 17'h1FFF8};
    vecs[6] = '{17'h00200, 18'd3,  0,  8'hFF,       0, 4'd0, 17'h00202};
    vecs[7] = '{17'h00201, 18'd1,  0,  8'hFF,       0, 4'd0, 17'h00201};
    vf      = '{17'h00100, 18'd6,  0,  8'hFF,       0, 4'd0, 17'h00105};

    reset = 1'b1; start = 1'b0; flush = 1'b0; out_ready = 1'b0;
    base_addr = '0; word_count = '0;
    tick();
    tick();
    check_reset_state("reset");
    reset = 1'b0;
    tick();

    // flush wins over start when both arrive in IDLE
    base_addr = 17'h00020; word_count = 18'd5; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_vs_start_busy", 32'(busy), 32'd0);
    chk("flush_vs_start_ren",  32'(ram_ren), 32'd0);
    tick();
    chk("flush_vs_start_done", 32'(done), 32'd0);

    for (int k = 0; k < 8; k++) run_xfer(vecs[k]);

    // flush four cycles into a long run, restart while the stale read returns
    start_and_run(17'h00500, 18'd50, 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_level", 32'(level),     32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ren",   32'(ram_ren),   32'd0);
    chk("flush_busy",  32'(busy),      32'd0);
    chk("flush_done",  32'(done),      32'd0);
    run_xfer(vf);

    // synchronous reset mid-run behaves the same
    start_and_run(17'h00500, 18'd50, 4);
    reset = 1'b1;
    tick();
    check_reset_state("midreset");
    reset = 1'b0;
    run_xfer(vf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
